// File: rtl/combine4mode_top.sv
// Four-mode LED pattern generator: a prescaler selected by freq_sel produces a
// step tick, and a registered 8-bit pattern advances once per tick.
module combine4mode_top #(
  parameter int DIV0  = 4096,
  parameter int DIV1  = 1024,
  parameter int DIV2  = 256,
  parameter int DIV3  = 64,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] freq_sel,
  input  logic [1:0] mode_sel,
  output logic [7:0] OUT
);

  localparam logic [CNT_W-1:0] DIV0_M1 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] DIV1_M1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] DIV2_M1 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] DIV3_M1 = CNT_W'(DIV3 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic [2:0]       idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       freq_q, freq_d;
  logic             started_q, started_d;

  logic             load;
  logic             freq_chg;
  logic             tick;
  logic [CNT_W-1:0] div_m1;
  logic [2:0]       idx_next;
  logic [7:0]       out_next;

  function automatic logic [7:0] init_pattern(input logic [1:0] m);
    case (m)
      2'd0:    init_pattern = 8'h01;
      2'd1:    init_pattern = 8'h80;
      2'd2:    init_pattern = 8'h01;
      default: init_pattern = 8'h81;
    endcase
  endfunction

  function automatic logic [7:0] converge_pattern(input logic [2:0] i);
    case (i)
      3'd0:    converge_pattern = 8'h81;
      3'd1:    converge_pattern = 8'h42;
      3'd2:    converge_pattern = 8'h24;
      3'd3:    converge_pattern = 8'h18;
      3'd4:    converge_pattern = 8'h24;
      3'd5:    converge_pattern = 8'h42;
      default: converge_pattern = 8'h81;
    endcase
  endfunction

  always_comb begin
    case (freq_q)
      2'd0:    div_m1 = DIV0_M1;
      2'd1:    div_m1 = DIV1_M1;
      2'd2:    div_m1 = DIV2_M1;
      default: div_m1 = DIV3_M1;
    endcase
  end

  // idx only sequences the converge/diverge mode; other modes derive the next
  // step from the current pattern itself.
  always_comb begin
    idx_next = idx_q + 3'd1;
    if (mode_q == 2'd3 && idx_q == 3'd5) idx_next = 3'd0;
    case (mode_q)
      2'd0:    out_next = {out_q[6:0], out_q[7]};
      2'd1:    out_next = {out_q[0], out_q[7:1]};
      2'd2:    out_next = (out_q == 8'hFF) ? 8'h00 : {out_q[6:0], 1'b1};
      default: out_next = converge_pattern(idx_next);
    endcase
  end

  // Priority: load (start-up or mode change) > frequency change > tick.
  always_comb begin
    load      = !started_q || (mode_sel != mode_q);
    freq_chg  = (freq_sel != freq_q);
    tick      = (cnt_q == div_m1);
    cnt_d     = cnt_q + CNT_W'(1);
    out_d     = out_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    freq_d    = freq_q;
    started_d = started_q;
    if (load) begin
      out_d     = init_pattern(mode_sel);
      idx_d     = 3'd0;
      cnt_d     = '0;
      mode_d    = mode_sel;
      freq_d    = freq_sel;
      started_d = 1'b1;
    end else if (freq_chg) begin
      cnt_d  = '0;
      freq_d = freq_sel;
    end else if (tick) begin
      cnt_d = '0;
      out_d = out_next;
      idx_d = idx_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      out_q     <= 8'h00;
      idx_q     <= 3'd0;
      mode_q    <= 2'd0;
      freq_q    <= 2'd0;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      freq_q    <= freq_d;
      started_q <= started_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_combine4mode_top.sv
// Directed bench for combine4mode_top: reset, per-mode sequences, mode and
// frequency changes, async reset mid-run. Inputs change and outputs are read on negedge.
module tb_combine4mode_top;

  logic       clk;
  logic       reset;
  logic [1:0] freq_sel;
  logic [1:0] mode_sel;
  logic [7:0] out_w;

  int checks = 0;
  int errors = 0;

  localparam int LIMIT = 10000;

  combine4mode_top dut (
    .clk      (clk),
    .reset    (reset),
    .freq_sel (freq_sel),
    .mode_sel (mode_sel),
    .OUT      (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written pattern tables, entry k of each mode's cycle.
  function automatic logic [7:0] exp_pat(input int m, input int k);
    logic [7:0] t0 [0:7];
    logic [7:0] t1 [0:7];
    logic [7:0] t2 [0:8];
    logic [7:0] t3 [0:5];
    t0 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    t1 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    t2 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    t3 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42};
    case (m)
      0:       exp_pat = t0[k % 8];
      1:       exp_pat = t1[k % 8];
      2:       exp_pat = t2[k % 9];
      default: exp_pat = t3[k % 6];
    endcase
  endfunction

  function automatic int seq_len(input int m);
    case (m)
      0, 1:    seq_len = 8;
      2:       seq_len = 9;
      default: seq_len = 6;
    endcase
  endfunction

  // Counts negedges until OUT differs from its value on entry (bounded).
  task automatic wait_change(output int cycles);
    logic [7:0] prev;
    prev   = out_w;
    cycles = 0;
    while (out_w === prev && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    int c;
    int total;
    reset    = 1'b0;
    mode_sel = 2'd0;
    freq_sel = 2'd3;
    repeat (5) @(negedge clk);
    checks++;
    if (out_w !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: OUT=%h expected=00", out_w);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_w !== 8'h01) begin
      errors++;
      $display("FAIL reset_release_load: OUT=%h expected=01", out_w);
    end
    total = 0;
    for (int k = 1; k <= 8; k++) begin
      wait_change(c);
      total += c;
      checks++;
      if (c !== 64 || out_w !== exp_pat(0, k)) begin
        errors++;
        $display("FAIL mode0_step%0d: period=%0d OUT=%h expected period=64 OUT=%h",
                 k, c, out_w, exp_pat(0, k));
      end
    end
    checks++;
    if (total !== 512 || out_w !== 8'h01) begin
      errors++;
      $display("FAIL mode0_wrap: cycles=%0d OUT=%h expected cycles=512 OUT=01", total, out_w);
    end
  endtask

  task automatic test_mode_sweep();
    int c;
    for (int m = 1; m <= 3; m++) begin
      mode_sel = 2'(m);
      @(negedge clk);
      checks++;
      if (out_w !== exp_pat(m, 0)) begin
        errors++;
        $display("FAIL mode%0d_load: OUT=%h expected=%h", m, out_w, exp_pat(m, 0));
      end
      for (int k = 1; k <= seq_len(m); k++) begin
        wait_change(c);
        checks++;
        if (c !== 64 || out_w !== exp_pat(m, k)) begin
          errors++;
          $display("FAIL mode%0d_step%0d: period=%0d OUT=%h expected period=64 OUT=%h",
                   m, k, c, out_w, exp_pat(m, k));
        end
      end
    end
  endtask

  task automatic test_mid_mode_change();
    int c;
    mode_sel = 2'd0;
    @(negedge clk);
    checks++;
    if (out_w !== 8'h01) begin
      errors++;
      $display("FAIL midchg_load0: OUT=%h expected=01", out_w);
    end
    c = 0;
    while (out_w !== 8'h10 && c < 4 * LIMIT) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (out_w !== 8'h10) begin
      errors++;
      $display("FAIL midchg_reach10: OUT=%h expected=10", out_w);
    end
    mode_sel = 2'd1;
    @(negedge clk);
    checks++;
    if (out_w !== 8'h80) begin
      errors++;
      $display("FAIL midchg_load1: OUT=%h expected=80", out_w);
    end
    wait_change(c);
    checks++;
    if (c !== 64 || out_w !== 8'h40) begin
      errors++;
      $display("FAIL midchg_first_step: period=%0d OUT=%h expected period=64 OUT=40", c, out_w);
    end
  endtask

  task automatic test_freq_sweep();
    int c;
    int divs [0:2];
    logic [7:0] held;
    divs = '{256, 1024, 4096};
    mode_sel = 2'd0;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      held     = out_w;
      freq_sel = 2'(2 - f);
      @(negedge clk);
      checks++;
      if (out_w !== held) begin
        errors++;
        $display("FAIL freq%0d_hold: OUT=%h expected=%h", 2 - f, out_w, held);
      end
      for (int r = 0; r < 2; r++) begin
        wait_change(c);
        checks++;
        if (c !== divs[f]) begin
          errors++;
          $display("FAIL freq%0d_period%0d: period=%0d expected=%0d", 2 - f, r, c, divs[f]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int c;
    freq_sel = 2'd3;
    mode_sel = 2'd2;
    @(negedge clk);
    c = 0;
    while (out_w !== 8'hFF && c < LIMIT) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (out_w !== 8'hFF) begin
      errors++;
      $display("FAIL areset_reachFF: OUT=%h expected=FF", out_w);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_w !== 8'h00) begin
      errors++;
      $display("FAIL areset_async: OUT=%h expected=00", out_w);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_w !== 8'h00) begin
      errors++;
      $display("FAIL areset_hold: OUT=%h expected=00", out_w);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_w !== 8'h01) begin
      errors++;
      $display("FAIL areset_reload: OUT=%h expected=01", out_w);
    end
  endtask

  task automatic test_simultaneous();
    int c;
    mode_sel = 2'd1;
    freq_sel = 2'd2;
    @(negedge clk);
    checks++;
    if (out_w !== 8'h80) begin
      errors++;
      $display("FAIL simul_load: OUT=%h expected=80", out_w);
    end
    wait_change(c);
    checks++;
    if (c !== 256 || out_w !== 8'h40) begin
      errors++;
      $display("FAIL simul_first_step: period=%0d OUT=%h expected period=256 OUT=40", c, out_w);
    end
  endtask

  initial begin
    reset    = 1'b0;
    freq_sel = 2'd0;
    mode_sel = 2'd0;
    test_reset();
    test_mode_sweep();
    test_mid_mode_change();
    test_freq_sweep();
    test_async_reset();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
